// File: rtl/rotate_pkg.sv
// rotate_pkg -- shared constants for the input buffer controller.
//   State encoding, default fill/drain sizes, the parked write address and
//   a helper that maps a pixel index and colour lane to a buffer byte address.
package rotate_pkg;

  localparam int WORDS_DEF  = 48;
  localparam int PIXELS_DEF = 64;
  localparam int CNT_W      = 6;

  localparam logic [7:0] ADDR_PARK = 8'd255;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Byte address of colour lane ch (0=B, 1=G, 2=R) of pixel p: 3p + ch.
  function automatic logic [7:0] pix_addr(input logic [CNT_W-1:0] p,
                                          input logic [1:0]       ch);
    logic [7:0] p8;
    p8 = {2'b00, p};
    return p8 + p8 + p8 + {6'b000000, ch};
  endfunction

endpackage

// File: rtl/imem_rd_seq.sv
// imem_rd_seq -- drain-side read sequencer.
//   Walks the pixel counter while drain_i is high, producing the B/G/R read
//   addresses, the padding flag and a PIX_VALID delayed one cycle to match
//   the buffer read latency.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   drain_i            controller is in DRAIN
//   clear_i            abort: drop progress and suppress the pending valid
//   pix_ready_i        downstream accepts the current pixel
//   valid_pix_i        number of real pixels; the rest are padding
//   addr_b/g/r_o       buffer read addresses (0 outside DRAIN)
//   pad_o              current pixel is padding
//   pix_valid_o        read data valid (one cycle after an issue)
//   last_o             final pixel issued this cycle
// Build option: ICTL_PAD_EN enables padding; otherwise pad_o is tied low.
module imem_rd_seq
  import rotate_pkg::*;
#(
  parameter int PIXELS = PIXELS_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       drain_i,
  input  logic       clear_i,
  input  logic       pix_ready_i,
  input  logic [6:0] valid_pix_i,
  output logic [7:0] addr_b_o,
  output logic [7:0] addr_g_o,
  output logic [7:0] addr_r_o,
  output logic       pad_o,
  output logic       pix_valid_o,
  output logic       last_o
);

  logic [CNT_W-1:0] pix_q, pix_d;
  logic             pix_valid_q, pix_valid_d;
  logic             issue;

  assign issue  = drain_i & pix_ready_i;
  assign last_o = issue & (pix_q == CNT_W'(PIXELS - 1));

  // Counter is held at zero outside DRAIN so every drain starts at pixel 0.
  always_comb begin
    pix_d = '0;
    if (drain_i && !clear_i) begin
      pix_d = issue ? pix_q + 1'b1 : pix_q;
    end
  end

  assign pix_valid_d = issue & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign pix_valid_o = pix_valid_q;
  assign addr_b_o    = drain_i ? pix_addr(pix_q, 2'd0) : 8'd0;
  assign addr_g_o    = drain_i ? pix_addr(pix_q, 2'd1) : 8'd0;
  assign addr_r_o    = drain_i ? pix_addr(pix_q, 2'd2) : 8'd0;

`ifdef ICTL_PAD_EN
  // 7-bit compare: VALID_PIX=0 pads everything, >=PIXELS pads nothing.
  assign pad_o = drain_i & ({1'b0, pix_q} >= valid_pix_i);
`else
  logic unused_valid_pix;
  assign unused_valid_pix = ^valid_pix_i;
  assign pad_o            = 1'b0;
`endif

endmodule

// File: rtl/input_mem_ctrl.sv
// input_mem_ctrl -- fills a 192-byte pixel buffer from AHB read data, then
// drains it as BGR pixels to a downstream consumer.
//   state | meaning
//   IDLE  | waiting for START
//   FILL  | accepting WORDS words, RREADY high
//   DRAIN | issuing PIXELS pixels, advancing on PIX_READY
//   DONE  | single-cycle completion pulse
// Ports:
//   I_ICTL_HCLK, I_ICTL_HRESET_N     clock, async active-low reset
//   I_ICTL_START, I_ICTL_ABORT       begin a cycle / return to IDLE
//   I_ICTL_RVALID, O_ICTL_RREADY     AHB read handshake
//   O_ICTL_IN_ADDR0..3, O_ICTL_WRITE buffer byte write addresses / enable
//   I_ICTL_PIX_READY, I_ICTL_VALID_PIX  drain flow control / real pixel count
//   O_ICTL_OUT_ADDRB/G/R             buffer read addresses
//   O_ICTL_PAD, O_ICTL_PIX_VALID, O_ICTL_DONE, O_ICTL_BUSY  status
// Build option: ICTL_PAD_EN enables PAD generation (see imem_rd_seq).
module input_mem_ctrl
  import rotate_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int PIXELS = PIXELS_DEF
) (
  input  logic       I_ICTL_HCLK,
  input  logic       I_ICTL_HRESET_N,
  input  logic       I_ICTL_START,
  input  logic       I_ICTL_ABORT,
  input  logic       I_ICTL_RVALID,
  output logic       O_ICTL_RREADY,
  input  logic       I_ICTL_PIX_READY,
  input  logic [6:0] I_ICTL_VALID_PIX,
  output logic [7:0] O_ICTL_IN_ADDR0,
  output logic [7:0] O_ICTL_IN_ADDR1,
  output logic [7:0] O_ICTL_IN_ADDR2,
  output logic [7:0] O_ICTL_IN_ADDR3,
  output logic       O_ICTL_WRITE,
  output logic [7:0] O_ICTL_OUT_ADDRB,
  output logic [7:0] O_ICTL_OUT_ADDRG,
  output logic [7:0] O_ICTL_OUT_ADDRR,
  output logic       O_ICTL_PAD,
  output logic       O_ICTL_PIX_VALID,
  output logic       O_ICTL_DONE,
  output logic       O_ICTL_BUSY
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic             in_fill, in_drain, accept, last_pix;

  assign in_fill  = (state_q == ST_FILL);
  assign in_drain = (state_q == ST_DRAIN);
  assign accept   = in_fill & I_ICTL_RVALID;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (I_ICTL_START) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (accept) begin
          if (word_q == CNT_W'(WORDS - 1)) begin
            state_d = ST_DRAIN;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (last_pix) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over START and over a final word/pixel in the same cycle.
    if (I_ICTL_ABORT) begin
      state_d = ST_IDLE;
      word_d  = '0;
    end
  end

  always_ff @(posedge I_ICTL_HCLK or negedge I_ICTL_HRESET_N) begin
    if (!I_ICTL_HRESET_N) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  assign O_ICTL_RREADY = in_fill;
  // Buffer only retains data while WRITE is high, so keep it up through DRAIN.
  assign O_ICTL_WRITE  = in_fill | in_drain;
  assign O_ICTL_BUSY   = in_fill | in_drain;
  assign O_ICTL_DONE   = (state_q == ST_DONE);

  assign O_ICTL_IN_ADDR0 = accept ? {word_q, 2'd0} : ADDR_PARK;
  assign O_ICTL_IN_ADDR1 = accept ? {word_q, 2'd1} : ADDR_PARK;
  assign O_ICTL_IN_ADDR2 = accept ? {word_q, 2'd2} : ADDR_PARK;
  assign O_ICTL_IN_ADDR3 = accept ? {word_q, 2'd3} : ADDR_PARK;

  imem_rd_seq #(.PIXELS(PIXELS)) u_rd_seq (
    .clk_i       (I_ICTL_HCLK),
    .rst_ni      (I_ICTL_HRESET_N),
    .drain_i     (in_drain),
    .clear_i     (I_ICTL_ABORT),
    .pix_ready_i (I_ICTL_PIX_READY),
    .valid_pix_i (I_ICTL_VALID_PIX),
    .addr_b_o    (O_ICTL_OUT_ADDRB),
    .addr_g_o    (O_ICTL_OUT_ADDRG),
    .addr_r_o    (O_ICTL_OUT_ADDRR),
    .pad_o       (O_ICTL_PAD),
    .pix_valid_o (O_ICTL_PIX_VALID),
    .last_o      (last_pix)
  );

endmodule

// File: tb/tb_input_mem_ctrl.sv
// tb_input_mem_ctrl -- self-checking bench for input_mem_ctrl.
// Build option: ICTL_PAD_EN selects the padding expectations.
module tb_input_mem_ctrl;

  localparam int WORDS  = 48;
  localparam int PIXELS = 64;
`ifdef ICTL_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam logic [61:0] RESET_SNAP = {6'b0, 24'd0, 32'hFFFF_FFFF};

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, rvalid = 1'b0, pix_ready = 1'b0;
  logic [6:0] valid_pix = 7'd60;
  logic       rready, write, pad, pix_valid, done, busy;
  logic [7:0] ia0, ia1, ia2, ia3, ob, og, orr;

  int total = 0;
  int passed = 0;

  input_mem_ctrl dut (
    .I_ICTL_HCLK      (clk),
    .I_ICTL_HRESET_N  (rst_n),
    .I_ICTL_START     (start),
    .I_ICTL_ABORT     (abort),
    .I_ICTL_RVALID    (rvalid),
    .O_ICTL_RREADY    (rready),
    .I_ICTL_PIX_READY (pix_ready),
    .I_ICTL_VALID_PIX (valid_pix),
    .O_ICTL_IN_ADDR0  (ia0),
    .O_ICTL_IN_ADDR1  (ia1),
    .O_ICTL_IN_ADDR2  (ia2),
    .O_ICTL_IN_ADDR3  (ia3),
    .O_ICTL_WRITE     (write),
    .O_ICTL_OUT_ADDRB (ob),
    .O_ICTL_OUT_ADDRG (og),
    .O_ICTL_OUT_ADDRR (orr),
    .O_ICTL_PAD       (pad),
    .O_ICTL_PIX_VALID (pix_valid),
    .O_ICTL_DONE      (done),
    .O_ICTL_BUSY      (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [61:0] snap();
    return {rready, write, pix_valid, pad, done, busy, ob, og, orr, ia0, ia1, ia2, ia3};
  endfunction

  // Drive inputs just after the falling edge and observe 2 ns later.
  task automatic cyc(input logic s, input logic a, input logic rv, input logic pr);
    @(negedge clk);
    start = s; abort = a; rvalid = rv; pix_ready = pr;
    #2;
  endtask

  task automatic do_fill(input bit gaps, output int cycles);
    int k;
    logic rv;
    logic [31:0] exp_in;
    cyc(1, 0, 0, 0);
    total++;
    if (busy !== 1'b0) $display("FAIL fill_start_idle: busy=%b want 0", busy);
    else passed++;
    k = 0;
    cycles = 0;
    while (k < WORDS && cycles < 400) begin
      rv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(0, 0, rv, 0);
      cycles++;
      exp_in = rv ? {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)} : {4{8'd255}};
      total++;
      if ({rready, write, busy, done, ia0, ia1, ia2, ia3} !== {4'b1110, exp_in})
        $display("FAIL fill_word%0d: rready=%b write=%b busy=%b done=%b addr=%h want addr=%h",
                 k, rready, write, busy, done, {ia0, ia1, ia2, ia3}, exp_in);
      else passed++;
      if (rv) k++;
    end
    total++;
    if (k != WORDS) $display("FAIL fill_budget: accepted %0d want %0d", k, WORDS);
    else passed++;
    cyc(0, 0, 0, 0);
    total++;
    if ({rready, write, busy, ia0, ob, og, orr} !== {3'b011, 8'd255, 8'd0, 8'd1, 8'd2})
      $display("FAIL fill_to_drain: rready=%b write=%b busy=%b ia0=%0d out=%0d/%0d/%0d want 0 1 1 255 0/1/2",
               rready, write, busy, ia0, ob, og, orr);
    else passed++;
  endtask

  // mode 0: PIX_READY 1010..., mode 1: random. Starts on the first DRAIN cycle.
  task automatic do_drain(input int mode, input logic [6:0] vp);
    int p, n, pulses, dones, pads, exp_pads;
    logic pr, prev, exp_pad, seen_done;
    valid_pix = vp;
    p = 0; n = 0; pulses = 0; dones = 0; pads = 0;
    prev = 1'b0; seen_done = 1'b0;
    while (!seen_done && n < 1000) begin
      pr = (mode == 0) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      cyc(0, 0, 0, pr);
      n++;
      if (pix_valid === 1'b1) pulses++;
      if (done === 1'b1) dones++;
      if (p < PIXELS) begin
        exp_pad = PAD_EN && (p >= int'(vp));
        total++;
        if ({busy, done, pix_valid, pad, ob, og, orr} !==
            {1'b1, 1'b0, prev, exp_pad, 8'(3*p), 8'(3*p+1), 8'(3*p+2)})
          $display("FAIL drain_p%0d: busy=%b done=%b pv=%b pad=%b out=%0d/%0d/%0d want 1 0 %b %b %0d/%0d/%0d",
                   p, busy, done, pix_valid, pad, ob, og, orr, prev, exp_pad, 3*p, 3*p+1, 3*p+2);
        else passed++;
        if (pr && exp_pad) pads++;
        prev = pr;
        if (pr) p++;
      end else begin
        total++;
        if ({busy, done, pix_valid, ob} !== {1'b0, 1'b1, prev, 8'd0})
          $display("FAIL drain_done: busy=%b done=%b pv=%b ob=%0d want 0 1 %b 0",
                   busy, done, pix_valid, ob, prev);
        else passed++;
        seen_done = 1'b1;
      end
    end
    cyc(0, 0, 0, 0);
    total++;
    if ({busy, done, pix_valid, rready, write} !== 5'b0)
      $display("FAIL drain_idle: busy=%b done=%b pv=%b rready=%b write=%b want all 0",
               busy, done, pix_valid, rready, write);
    else passed++;
    exp_pads = !PAD_EN ? 0 : (int'(vp) >= PIXELS) ? 0 : PIXELS - int'(vp);
    total++;
    if (pulses != PIXELS || dones != 1 || pads != exp_pads || !seen_done)
      $display("FAIL drain_counts: pulses=%0d dones=%0d pads=%0d done_seen=%b want %0d 1 %0d 1",
               pulses, dones, pads, seen_done, PIXELS, exp_pads);
    else passed++;
  endtask

  task automatic test_reset();
    #5;
    total++;
    if (snap() !== RESET_SNAP) $display("FAIL reset_outputs: got %h want %h", snap(), RESET_SNAP);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 1);
    total++;
    if (snap() !== RESET_SNAP) $display("FAIL reset_idle: got %h want %h", snap(), RESET_SNAP);
    else passed++;
  endtask

  task automatic test_fill_full();
    int cycles;
    do_fill(1'b0, cycles);
    total++;
    if (cycles != WORDS) $display("FAIL fill_full_cycles: got %0d want %0d", cycles, WORDS);
    else passed++;
    do_drain(0, 7'd60);
  endtask

  task automatic test_fill_gaps();
    int cycles;
    do_fill(1'b1, cycles);
    do_drain(1, 7'd0);
  endtask

  task automatic test_abort_fill();
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    total++;
    if (busy !== 1'b0) $display("FAIL abort_beats_start: busy=%b want 0", busy);
    else passed++;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    total++;
    if (ia0 !== 8'd80) $display("FAIL abort_word20_addr: ia0=%0d want 80", ia0);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      total++;
      if ({busy, rready, done, write, ia0} !== {4'b0, 8'd255})
        $display("FAIL abort_fill_idle%0d: busy=%b rready=%b done=%b write=%b ia0=%0d want 0 0 0 0 255",
                 i, busy, rready, done, write, ia0);
      else passed++;
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    total++;
    if ({rready, ia0, ia3} !== {1'b1, 8'd0, 8'd3})
      $display("FAIL abort_refill: rready=%b ia0=%0d ia3=%0d want 1 0 3", rready, ia0, ia3);
    else passed++;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    total++;
    if (busy !== 1'b0) $display("FAIL abort_refill_idle: busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_abort_last_pixel();
    int cycles;
    do_fill(1'b0, cycles);
    for (int p = 0; p < PIXELS - 1; p++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    total++;
    if (ob !== 8'd189) $display("FAIL abort_last_addr: ob=%0d want 189", ob);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      total++;
      if ({busy, done, ob} !== {2'b00, 8'd0})
        $display("FAIL abort_last_idle%0d: busy=%b done=%b ob=%0d want 0 0 0", i, busy, done, ob);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_drain();
    int cycles;
    do_fill(1'b0, cycles);
    valid_pix = 7'd20;
    for (int p = 0; p < 30; p++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    total++;
    if ({ob, pix_valid, pad} !== {8'd90, 1'b1, PAD_EN})
      $display("FAIL mid_drain_p30: ob=%0d pv=%b pad=%b want 90 1 %b", ob, pix_valid, pad, PAD_EN);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (snap() !== RESET_SNAP) $display("FAIL reset_async: got %h want %h", snap(), RESET_SNAP);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1);
    total++;
    if (snap() !== RESET_SNAP) $display("FAIL reset_after: got %h want %h", snap(), RESET_SNAP);
    else passed++;
    do_fill(1'b1, cycles);
    do_drain(1, 7'd30);
  endtask

  task automatic test_back_to_back();
    int cycles;
    logic [6:0] vps [3];
    vps[0] = 7'd100;
    vps[1] = 7'd64;
    vps[2] = 7'($urandom_range(0, 127));
    for (int i = 0; i < 3; i++) begin
      do_fill(1'b1, cycles);
      do_drain(1, vps[i]);
    end
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_fill_gaps();
    test_abort_fill();
    test_abort_last_pixel();
    test_reset_mid_drain();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
